// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction prefetch queue feeding the IF stage. It owns the fetch address,
// issues at most one word read per cycle to a synchronous instruction ROM
// (data returns the cycle after the request) and buffers the returned words
// together with their addresses in a DEPTH-entry FIFO. A redirect flushes
// the FIFO, drops the outstanding read and restarts fetch at redirect_pc.
//
// Optional feature (compile-time macro IFQ_BYPASS_EN):
//   defined     - a response arriving while the FIFO is empty is shown on
//                 instr/instr_pc in the same cycle; if deq is also high the
//                 word is consumed and never written to the FIFO.
//   not defined - responses are visible only after being written to the
//                 FIFO; instr has no combinational path from imem_rdata.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   AW        word-address width of the instruction ROM
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  read request this cycle
//   imem_addr    out  word address of the request (current fetch pointer)
//   imem_rdata   in   ROM data, valid the cycle after a request
//   redirect     in   flush queue, restart fetch at redirect_pc
//   redirect_pc  in   new fetch address
//   deq          in   pipeline consumes the head entry this cycle
//   valid        out  head entry present
//   instr        out  head instruction, zero when !valid
//   instr_pc     out  head address, zero when !valid
//   count        out  occupied FIFO entries
// ---------------------------------------------------------------------------
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_req,
    output logic [AW-1:0]                imem_addr,
    input  logic [31:0]                  imem_rdata,
    input  logic                         redirect,
    input  logic [AW-1:0]                redirect_pc,
    input  logic                         deq,
    output logic                         valid,
    output logic [31:0]                  instr,
    output logic [AW-1:0]                instr_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [AW-1:0] RESET_FPC = AW'(RESET_PC);

    // Control state
    logic [AW-1:0] r_fpc;
    logic          r_inflight;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Data state (no reset: contents are masked until counted as valid)
    logic [AW-1:0] r_inflight_pc;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [AW-1:0] r_mem_pc    [DEPTH];

    logic [CW:0]   w_occupancy;
    logic          w_credit_ok;
    logic          w_req;
    logic          w_fifo_empty;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;

    // Credit covers both stored words and the read still in flight, so a
    // response always has a free slot. A same-cycle deq earns no credit.
    assign w_occupancy  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit_ok  = (w_occupancy < (CW+1)'(DEPTH));
    assign w_req        = !redirect && w_credit_ok;
    assign w_fifo_empty = (r_count == '0);

`ifdef IFQ_BYPASS_EN
    // The arriving word is the head when nothing is stored ahead of it.
    assign w_bypass = r_inflight && w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that is consumed immediately never occupies a slot.
    assign w_push = r_inflight && !redirect && !(w_bypass && deq);
    assign w_pop  = deq && !w_fifo_empty && !redirect;

    assign imem_req  = w_req;
    assign imem_addr = r_fpc;
    assign valid     = !w_fifo_empty || w_bypass;
    assign count     = r_count;

    // Head presentation: stored entry first, otherwise the bypassed response,
    // otherwise all-zero (a NOP for the IF register).
    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (!w_fifo_empty) begin
            instr    = r_mem_instr[r_head];
            instr_pc = r_mem_pc[r_head];
        end
`ifdef IFQ_BYPASS_EN
        else if (w_bypass) begin
            instr    = imem_rdata;
            instr_pc = r_inflight_pc;
        end
`endif
    end

    // Control registers: fetch pointer, in-flight flag, FIFO pointers/count.
    // Redirect wins over everything, including a same-cycle deq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc      <= RESET_FPC;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fpc      <= redirect_pc;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_req) begin
                r_fpc      <= r_fpc + AW'(1);
                r_inflight <= 1'b1;
            end else begin
                r_inflight <= 1'b0;
            end

            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data registers: address of the outstanding read and FIFO storage.
    always_ff @(posedge clk) begin
        if (w_req) begin
            r_inflight_pc <= r_fpc;
        end
        if (w_push) begin
            r_mem_instr[r_tail] <= imem_rdata;
            r_mem_pc[r_tail]    <= r_inflight_pc;
        end
    end

endmodule
